// File: rtl/result_bcd_decoder_if.sv
// Start/busy/done handshake and result bus between the ALU result register
// and the display logic of the sequential BCD decoder.
interface result_bcd_decoder_if #(
   parameter int WORD_LENGTH = 8,
   parameter int DIGITS      = 3
);
   logic [WORD_LENGTH-1:0] Data_in;
   logic                   start;
   logic                   Busy;
   logic                   Done;
   logic                   Sign_out;
   logic [4*DIGITS-1:0]    Bcd_out;
   logic                   Overflow;

   modport master (
      output Data_in, start,
      input  Busy, Done, Sign_out, Bcd_out, Overflow
   );

   modport slave (
      input  Data_in, start,
      output Busy, Done, Sign_out, Bcd_out, Overflow
   );
endinterface

// File: rtl/result_bcd_decoder.sv
// Iterative shift-and-add-3 binary-to-BCD converter with sign extraction and
// sticky overflow; results are published only when a conversion completes.
module result_bcd_decoder #(
   parameter int WORD_LENGTH = 8,
   parameter int DIGITS      = 3,
   parameter int SIGNED      = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   result_bcd_decoder_if.slave   bus
);
   localparam int CNT_W = $clog2(WORD_LENGTH + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [WORD_LENGTH-1:0] mag_q, mag_d;
   logic [BCD_W-1:0]       scr_q, scr_d;
   logic                   sticky_q;
   logic                   sign_q;
   logic                   carry_d;
   logic                   busy_q, done_q, sign_out_q, ovf_out_q;
   logic [BCD_W-1:0]       bcd_out_q;

   logic                   neg_in;
   logic [WORD_LENGTH-1:0] mag_in;
   logic [BCD_W-1:0]       adj;

   // Capture-side sign/magnitude; the most negative value maps to 2^(W-1) exactly.
   always_comb begin
      neg_in = (SIGNED != 0) && bus.Data_in[WORD_LENGTH-1];
      mag_in = neg_in ? (~bus.Data_in + 1'b1) : bus.Data_in;
   end

   always_comb begin
      adj = scr_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      {carry_d, scr_d, mag_d} = {adj, mag_q, 1'b0};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mag_q      <= '0;
         scr_q      <= '0;
         sticky_q   <= 1'b0;
         sign_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sign_out_q <= 1'b0;
         ovf_out_q  <= 1'b0;
         bcd_out_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  sign_q   <= neg_in;
                  mag_q    <= mag_in;
                  scr_q    <= '0;
                  sticky_q <= 1'b0;
                  cnt_q    <= CNT_W'(WORD_LENGTH);
                  state_q  <= SHIFT;
                  busy_q   <= 1'b1;
               end
            end
            SHIFT: begin
               scr_q    <= scr_d;
               mag_q    <= mag_d;
               sticky_q <= sticky_q | carry_d;
               cnt_q    <= cnt_q - 1'b1;
               // Last shift: publish directly from the shifter so no partial value is ever visible.
               if (cnt_q == CNT_W'(1)) begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  bcd_out_q  <= scr_d;
                  sign_out_q <= sign_q;
                  ovf_out_q  <= sticky_q | carry_d;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Busy     = busy_q;
   assign bus.Done     = done_q;
   assign bus.Sign_out = sign_out_q;
   assign bus.Bcd_out  = bcd_out_q;
   assign bus.Overflow = ovf_out_q;
endmodule

// File: tb/tb_result_bcd_decoder.sv
// Bench for result_bcd_decoder: three configurations (signed 3-digit,
// unsigned 3-digit, unsigned 2-digit) against an arithmetic reference model.
module tb_result_bcd_decoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   result_bcd_decoder_if #(.WORD_LENGTH(8), .DIGITS(3)) if0 ();
   result_bcd_decoder_if #(.WORD_LENGTH(8), .DIGITS(3)) if1 ();
   result_bcd_decoder_if #(.WORD_LENGTH(8), .DIGITS(2)) if2 ();

   result_bcd_decoder #(.WORD_LENGTH(8), .DIGITS(3), .SIGNED(1)) dut0 (.clock(clk), .reset(rst_n), .bus(if0.slave));
   result_bcd_decoder #(.WORD_LENGTH(8), .DIGITS(3), .SIGNED(0)) dut1 (.clock(clk), .reset(rst_n), .bus(if1.slave));
   result_bcd_decoder #(.WORD_LENGTH(8), .DIGITS(2), .SIGNED(0)) dut2 (.clock(clk), .reset(rst_n), .bus(if2.slave));

   typedef struct {
      int         k;
      logic [7:0] v;
      logic [11:0] b;
      logic       s;
      logic       o;
   } vec_t;

   typedef struct {
      logic       busy;
      logic       done;
      logic       sign;
      logic [11:0] bcd;
      logic       ovf;
   } obs_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input int k, input logic [7:0] v, input logic st);
      case (k)
         0: begin if0.Data_in = v; if0.start = st; end
         1: begin if1.Data_in = v; if1.start = st; end
         default: begin if2.Data_in = v; if2.start = st; end
      endcase
   endtask

   function automatic obs_t get(input int k);
      obs_t o;
      case (k)
         0: begin o.busy = if0.Busy; o.done = if0.Done; o.sign = if0.Sign_out; o.bcd = if0.Bcd_out; o.ovf = if0.Overflow; end
         1: begin o.busy = if1.Busy; o.done = if1.Done; o.sign = if1.Sign_out; o.bcd = if1.Bcd_out; o.ovf = if1.Overflow; end
         default: begin o.busy = if2.Busy; o.done = if2.Done; o.sign = if2.Sign_out; o.bcd = {4'h0, if2.Bcd_out}; o.ovf = if2.Overflow; end
      endcase
      return o;
   endfunction

   // Reference: decimal digits of |value| modulo 10^DIGITS, overflow if it does not fit.
   task automatic model(input int k, input logic [7:0] v, output logic [11:0] b, output logic s, output logic o);
      int val, mag, nd, md, r;
      val = (k == 0) ? int'($signed(v)) : int'(v);
      nd  = (k == 2) ? 2 : 3;
      md  = (k == 2) ? 100 : 1000;
      s   = (val < 0);
      mag = s ? -val : val;
      o   = (mag >= md);
      r   = mag % md;
      b   = '0;
      for (int i = 0; i < nd; i++) begin
         b[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge back in IDLE.
   task automatic convert(input int k, input logic [7:0] v, output obs_t res, output int lat);
      set_in(k, v, 1'b1);
      @(posedge clk);
      #1 set_in(k, v ^ 8'h5A, 1'b0);
      lat = -1;
      res = get(k);
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         if (get(k).done === 1'b1) begin
            lat = j;
            res = get(k);
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic check_conv(input string tag, input int k, input logic [7:0] v,
                             input logic [11:0] eb, input logic es, input logic eo);
      obs_t r;
      int   lat;
      convert(k, v, r, lat);
      chk({tag, " latency"}, 32'(lat), 32'd8);
      chk({tag, " bcd"}, 32'(r.bcd), 32'(eb));
      chk({tag, " sign"}, 32'(r.sign), 32'(es));
      chk({tag, " ovf"}, 32'(r.ovf), 32'(eo));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[9];
      obs_t o;
      int   busy_cnt, done_cnt, done_at, d_first, d_second;
      logic [11:0] eb;
      logic es, eo;
      logic [7:0] rv;

      tbl[0] = '{0, 8'd127, 12'h127, 1'b0, 1'b0};
      tbl[1] = '{0, 8'hFF,  12'h001, 1'b1, 1'b0};
      tbl[2] = '{0, 8'h80,  12'h128, 1'b1, 1'b0};
      tbl[3] = '{0, 8'hF6,  12'h010, 1'b1, 1'b0};
      tbl[4] = '{1, 8'hFF,  12'h255, 1'b0, 1'b0};
      tbl[5] = '{1, 8'h80,  12'h128, 1'b0, 1'b0};
      tbl[6] = '{2, 8'd99,  12'h099, 1'b0, 1'b0};
      tbl[7] = '{2, 8'd100, 12'h000, 1'b0, 1'b1};
      tbl[8] = '{2, 8'd255, 12'h055, 1'b0, 1'b1};

      for (int k = 0; k < 3; k++) set_in(k, 8'd0, 1'b0);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         o = get(k);
         chk("reset busy", 32'(o.busy), 32'd0);
         chk("reset done", 32'(o.done), 32'd0);
         chk("reset bcd", 32'(o.bcd), 32'd0);
         chk("reset sign", 32'(o.sign), 32'd0);
         chk("reset ovf", 32'(o.ovf), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Zero conversion with cycle-by-cycle Busy/Done timing.
      set_in(0, 8'd0, 1'b1);
      @(posedge clk);
      #1 set_in(0, 8'd0, 1'b0);
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      for (int j = 0; j < 14; j++) begin
         @(negedge clk);
         o = get(0);
         if (o.busy === 1'b1) busy_cnt++;
         if (o.done === 1'b1) begin
            done_cnt++;
            done_at = j;
            chk("zero bcd", 32'(o.bcd), 32'h000);
            chk("zero sign", 32'(o.sign), 32'd0);
            chk("zero ovf", 32'(o.ovf), 32'd0);
         end
      end
      chk("zero busy cycles", 32'(busy_cnt), 32'd9);
      chk("zero done pulses", 32'(done_cnt), 32'd1);
      chk("zero done index", 32'(done_at), 32'd8);

      foreach (tbl[i]) check_conv($sformatf("vec%0d", i), tbl[i].k, tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].o);

      for (int n = 0; n < 75; n++) begin
         rv = 8'($urandom_range(0, 255));
         if (n % 25 == 0) rv = 8'h80;
         if (n % 25 == 1) rv = 8'h7F;
         model(n % 3, rv, eb, es, eo);
         check_conv($sformatf("rand k%0d v%0h", n % 3, rv), n % 3, rv, eb, es, eo);
      end

      // start held high, Data_in = 5 + edge index.
      set_in(0, 8'd5, 1'b1);
      d_first = -1; d_second = -1;
      @(posedge clk);
      for (int j = 0; j <= 18; j++) begin
         @(negedge clk);
         o = get(0);
         if (o.done === 1'b1) begin
            if (d_first < 0) d_first = j; else d_second = j;
         end
         if (j >= 8 && j <= 17) chk($sformatf("held bcd j%0d", j), 32'(o.bcd), 32'h005);
         if (j == 9) chk("held busy gap", 32'(o.busy), 32'd0);
         if (j == 10) chk("held reaccept busy", 32'(o.busy), 32'd1);
         if (j == 18) begin
            chk("held second bcd", 32'(o.bcd), 32'h015);
            set_in(0, 8'd0, 1'b0);
         end else begin
            set_in(0, 8'(5 + j + 1), 1'b1);
         end
      end
      chk("held first done", 32'(d_first), 32'd8);
      chk("held second done", 32'(d_second), 32'd18);
      @(negedge clk);

      // Asynchronous reset in the middle of a conversion.
      set_in(0, 8'd200, 1'b1);
      @(posedge clk);
      #1 set_in(0, 8'd200, 1'b0);
      repeat (3) @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      o = get(0);
      chk("async busy", 32'(o.busy), 32'd0);
      chk("async done", 32'(o.done), 32'd0);
      chk("async bcd", 32'(o.bcd), 32'd0);
      chk("async sign", 32'(o.sign), 32'd0);
      chk("async ovf", 32'(o.ovf), 32'd0);
      done_cnt = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (get(0).done === 1'b1) done_cnt++;
         if (j == 2) rst_n = 1'b1;
      end
      chk("async no done", 32'(done_cnt), 32'd0);
      check_conv("after reset 42", 0, 8'd42, 12'h042, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
